mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory bus between two pipeline requesters: the fetch port (I) and the memory-stage port (D).
- Each transaction is single-beat. Once a transaction is granted, it holds the bus until the memory returns its response.
- A fetch can be squashed when the pipeline redirects on jump, exception or mret. The squashed fetch still completes on the bus, but its response is not delivered to fetch.
- The block sits between the core (fetch and memory stages) and the memory interface. The hazard unit sees its response pulses as the fetch/memory "done" signals.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width. Strobe width is DATA_W/8.
- MAX_DSTREAK, 3, the number of consecutive D grants allowed while I is waiting. After that, I is granted once. Must be ≥1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ireq_valid  in  1  fetch request pending.
- ireq_addr  in  ADDR_W  fetch address.
- ifetch_flush  in  1  pipeline redirect. Squashes any in-flight or pending fetch.
- iresp_valid  out  1  fetch response pulse.
- iresp_data  out  DATA_W  fetch data.
- dreq_valid  in  1  memory-stage request pending.
- dreq_addr  in  ADDR_W  data address.
- dreq_write  in  1  1 = store.
- dreq_size  in  3  access size (log2 bytes).
- dreq_strobe  in  DATA_W/8  byte enables.
- dreq_wdata  in  DATA_W  store data.
- dresp_valid  out  1  data response pulse.
- dresp_data  out  DATA_W  load data.
- mreq_valid  out  1  bus request.
- mreq_addr  out  ADDR_W  bus address.
- mreq_write  out  1  bus write.
- mreq_size  out  3  bus size.
- mreq_strobe  out  DATA_W/8  bus strobes.
- mreq_wdata  out  DATA_W  bus write data.
- mresp_valid  in  1  bus response, one cycle.
- mresp_data  in  DATA_W  bus read data.

Behaviour:
- State machine has three states: IDLE, BUSY_I, BUSY_D. Registers are state, captured request fields, streak counter (width = clog2(MAX_DSTREAK+1)), and the squash flag.
- Reset (resetn low at posedge):
  - state goes to IDLE; streak and squash go to 0.
  - mreq_valid, iresp_valid and dresp_valid read 0 from the following cycle.
  - Captured fields go to 0.
  - Reset in the middle of a transaction abandons it. The bus side tolerates a dropped request.
- Arbitration in IDLE:
  - I takes priority when ireq_valid && !ifetch_flush && (streak==MAX_DSTREAK || !dreq_valid).
  - Otherwise D is granted when dreq_valid.
  - Otherwise the block stays in IDLE.
  - A flushed fetch request is never granted in the cycle the flush is asserted.
- On grant:
  - The winner's fields are captured and the block enters BUSY_I or BUSY_D.
  - For an I grant, mreq_write=0, mreq_size=3 and mreq_strobe=0 are captured.
- BUSY states:
  - mreq_valid=1 and mreq_* are driven from the captured registers.
  - These outputs stay stable until completion, even if the requester changes its inputs.
  - Arbitration latency is 1 cycle: a request seen in IDLE at cycle N appears on the bus at N+1.
- Completion happens in the cycle mresp_valid=1 while in a BUSY state:
  - BUSY_D: dresp_valid=1 and dresp_data=mresp_data, combinationally in that cycle.
  - BUSY_I: iresp_valid=1 and iresp_data=mresp_data, unless squash or ifetch_flush is set that cycle. In that case iresp_valid=0.
  - Next state is IDLE. There is always at least one IDLE cycle between transactions.
  - squash is cleared.
- Squash:
  - ifetch_flush in BUSY_I sets squash.
  - ifetch_flush has no effect on D transactions.
- Streak counter:
  - On a D grant with ireq_valid high, streak increments and saturates at MAX_DSTREAK.
  - On a D grant with ireq_valid low, streak clears to 0.
  - On an I grant, streak clears to 0.
- Ignored inputs:
  - mresp_valid in IDLE is ignored; no response pulse is produced.
  - Requests arriving during BUSY wait. Requesters hold valid and fields stable until their response pulse.
- Idle outputs: outside a completion cycle, iresp_data and dresp_data are 0.

Test Plan:
- Single fetch:
  - Stimulus: ireq_valid, addr 0x8000_0000; mresp_valid 3 cycles after mreq_valid, data 0x13.
  - Required: mreq_valid at cycle 1, mreq_write=0; iresp_valid one cycle with data 0x13; IDLE next cycle.
- Simultaneous requests:
  - Stimulus: ireq and a dreq store (addr 0x100, strobe 0x0F, wdata 0xDEADBEEF) asserted together.
  - Required: D granted first with mreq_write=1 and the exact strobe/wdata; after dresp, I granted in the next IDLE cycle.
- Starvation bound (MAX_DSTREAK=3):
  - Stimulus: dreq_valid and ireq_valid held continuously.
  - Required: grant order D,D,D,I,D,D,D,I; streak returns to 0 after each I grant.
- Squash:
  - Stimulus: ifetch_flush pulsed in the 2nd cycle of BUSY_I.
  - Required: bus transaction still completes; iresp_valid stays 0; a following D request is granted normally.
- Reset mid-transaction:
  - Stimulus: resetn low during BUSY_D.
  - Required: next cycle mreq_valid=0 and state IDLE; a late mresp_valid produces no dresp_valid.
- Request stability:
  - Stimulus: dreq_addr changed from 0x200 to 0x300 while BUSY_D.
  - Required: mreq_addr stays 0x200 until completion.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundled request/response signals between the fetch port, memory-stage port and memory bus.
// The arbiter connects through the slave modport; the surrounding core/bus drives the master side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    // Fetch port
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              ifetch_flush;
    logic              iresp_valid;
    logic [DATA_W-1:0] iresp_data;

    // Memory-stage port
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_write;
    logic [2:0]        dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dresp_valid;
    logic [DATA_W-1:0] dresp_data;

    // Shared memory bus
    logic              mreq_valid;
    logic [ADDR_W-1:0] mreq_addr;
    logic              mreq_write;
    logic [2:0]        mreq_size;
    logic [STRB_W-1:0] mreq_strobe;
    logic [DATA_W-1:0] mreq_wdata;
    logic              mresp_valid;
    logic [DATA_W-1:0] mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr, ifetch_flush,
        output iresp_valid, iresp_data,
        input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        output dresp_valid, dresp_data,
        output mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
        input  mresp_valid, mresp_data
    );

    modport master (
        output ireq_valid, ireq_addr, ifetch_flush,
        input  iresp_valid, iresp_data,
        output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        input  dresp_valid, dresp_data,
        input  mreq_valid, mreq_addr, mreq_write, mreq_size, mreq_strobe, mreq_wdata,
        output mresp_valid, mresp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester single-beat memory bus arbiter: D has priority, bounded by a streak counter
// that guarantees the fetch port a grant after MAX_DSTREAK back-to-back D grants.
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int MAX_DSTREAK = 3
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam logic [2:0]          FETCH_SIZE = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D
    } state_e;

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                write_q,  write_d;
    logic [2:0]          size_q,   size_d;
    logic [STRB_W-1:0]   strobe_q, strobe_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                squash_q, squash_d;

    logic                iresp_valid;
    logic [DATA_W-1:0]   iresp_data;
    logic                dresp_valid;
    logic [DATA_W-1:0]   dresp_data;
    logic                grant_i;

    // Fetch wins when D is idle or has used up its streak; a flushing fetch never wins.
    assign grant_i = bus.ireq_valid && !bus.ifetch_flush &&
                     ((streak_q == STREAK_MAX) || !bus.dreq_valid);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            squash_q <= squash_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        strobe_d    = strobe_q;
        wdata_d     = wdata_q;
        streak_d    = streak_q;
        squash_d    = squash_q;
        iresp_valid = 1'b0;
        iresp_data  = '0;
        dresp_valid = 1'b0;
        dresp_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    state_d  = S_BUSY_I;
                    addr_d   = bus.ireq_addr;
                    write_d  = 1'b0;
                    size_d   = FETCH_SIZE;
                    strobe_d = '0;
                    wdata_d  = '0;
                    streak_d = '0;
                end else if (bus.dreq_valid) begin
                    state_d  = S_BUSY_D;
                    addr_d   = bus.dreq_addr;
                    write_d  = bus.dreq_write;
                    size_d   = bus.dreq_size;
                    strobe_d = bus.dreq_strobe;
                    wdata_d  = bus.dreq_wdata;
                    // Count only grants that actually made a fetch wait.
                    if (!bus.ireq_valid) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end

            S_BUSY_I: begin
                if (bus.mresp_valid) begin
                    // A squashed fetch still retires on the bus but is hidden from fetch.
                    iresp_valid = !(squash_q || bus.ifetch_flush);
                    iresp_data  = bus.mresp_data;
                    squash_d    = 1'b0;
                    state_d     = S_IDLE;
                end else if (bus.ifetch_flush) begin
                    squash_d = 1'b1;
                end
            end

            S_BUSY_D: begin
                if (bus.mresp_valid) begin
                    dresp_valid = 1'b1;
                    dresp_data  = bus.mresp_data;
                    squash_d    = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mreq_valid  = (state_q != S_IDLE);
    assign bus.mreq_addr   = addr_q;
    assign bus.mreq_write  = write_q;
    assign bus.mreq_size   = size_q;
    assign bus.mreq_strobe = strobe_q;
    assign bus.mreq_wdata  = wdata_q;

    assign bus.iresp_valid = iresp_valid;
    assign bus.iresp_data  = iresp_data;
    assign bus.dresp_valid = dresp_valid;
    assign bus.dresp_data  = dresp_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic flows,
// plus hand-written sequences for the starvation bound, squash and mid-transaction reset.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NV = 20;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_DSTREAK(3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // One record per clock cycle: inputs driven after the rising edge, outputs checked at the falling edge.
    typedef struct {
        logic        iv;
        logic [63:0] iaddr;
        logic        fl;
        logic        dv;
        logic [63:0] daddr;
        logic        dw;
        logic [7:0]  dstrb;
        logic [63:0] dwdata;
        logic        mv;
        logic [63:0] mdata;
        logic        e_mv;
        logic [63:0] e_maddr;
        logic        e_mw;
        logic [7:0]  e_mstrb;
        logic [63:0] e_mwdata;
        logic        e_iv;
        logic [63:0] e_idata;
        logic        e_dv;
        logic [63:0] e_ddata;
    } vec_t;

    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ireq_valid   = 1'b0;
        bus.ireq_addr    = '0;
        bus.ifetch_flush = 1'b0;
        bus.dreq_valid   = 1'b0;
        bus.dreq_addr    = '0;
        bus.dreq_write   = 1'b0;
        bus.dreq_size    = 3'd3;
        bus.dreq_strobe  = '0;
        bus.dreq_wdata   = '0;
        bus.mresp_valid  = 1'b0;
        bus.mresp_data   = '0;
    endtask

    // Leaves the bench at the falling edge of the first cycle with mreq_valid high, or after a bounded wait.
    task automatic wait_busy(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mreq_valid && n < 8) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n++;
        end
        check({name, " bus busy"}, 64'(bus.mreq_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            iv  iaddr           fl dv daddr   dw strb   dwdata          mv mdata    | e_mv e_maddr        e_mw e_strb e_wdata        e_iv e_idata e_dv e_ddata
        vecs[0]  = '{1, 64'h8000_0000, 0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[1]  = '{1, 64'h8000_0000, 0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    1, 64'h8000_0000,  0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[2]  = '{1, 64'h8000_0000, 0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    1, 64'h8000_0000,  0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[3]  = '{1, 64'h8000_0000, 0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    1, 64'h8000_0000,  0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[4]  = '{1, 64'h8000_0000, 0, 0, 64'h0,   0, 8'h00, 64'h0,          1, 64'h13,   1, 64'h8000_0000,  0, 8'h00, 64'h0,          1, 64'h13, 0, 64'h0};
        vecs[5]  = '{0, 64'h0,         0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[6]  = '{1, 64'h1000,      0, 1, 64'h100, 1, 8'h0F, 64'hDEAD_BEEF,  0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[7]  = '{1, 64'h1000,      0, 1, 64'h100, 1, 8'h0F, 64'hDEAD_BEEF,  0, 64'h0,    1, 64'h100,        1, 8'h0F, 64'hDEAD_BEEF,  0, 64'h0,  0, 64'h0};
        vecs[8]  = '{1, 64'h1000,      0, 1, 64'h100, 1, 8'h0F, 64'hDEAD_BEEF,  1, 64'h55,   1, 64'h100,        1, 8'h0F, 64'hDEAD_BEEF,  0, 64'h0,  1, 64'h55};
        vecs[9]  = '{1, 64'h1000,      0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[10] = '{1, 64'h1000,      0, 0, 64'h0,   0, 8'h00, 64'h0,          1, 64'h77,   1, 64'h1000,       0, 8'h00, 64'h0,          1, 64'h77, 0, 64'h0};
        vecs[11] = '{0, 64'h0,         0, 0, 64'h0,   0, 8'h00, 64'h0,          1, 64'h99,   0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[12] = '{0, 64'h0,         0, 1, 64'h200, 0, 8'hFF, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[13] = '{0, 64'h0,         0, 1, 64'h300, 0, 8'hFF, 64'h0,          0, 64'h0,    1, 64'h200,        0, 8'hFF, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[14] = '{0, 64'h0,         0, 1, 64'h300, 0, 8'hFF, 64'h0,          1, 64'hAB,   1, 64'h200,        0, 8'hFF, 64'h0,          0, 64'h0,  1, 64'hAB};
        vecs[15] = '{0, 64'h0,         0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[16] = '{1, 64'h2000,      1, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[17] = '{1, 64'h2000,      0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};
        vecs[18] = '{1, 64'h2000,      0, 0, 64'h0,   0, 8'h00, 64'h0,          1, 64'h3C,   1, 64'h2000,       0, 8'h00, 64'h0,          1, 64'h3C, 0, 64'h0};
        vecs[19] = '{0, 64'h0,         0, 0, 64'h0,   0, 8'h00, 64'h0,          0, 64'h0,    0, 64'h0,          0, 8'h00, 64'h0,          0, 64'h0,  0, 64'h0};

        // Reset
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset mreq_valid",  64'(bus.mreq_valid),  64'd0);
        check("reset iresp_valid", 64'(bus.iresp_valid), 64'd0);
        check("reset dresp_valid", 64'(bus.dresp_valid), 64'd0);
        check("reset streak",      64'(dut.streak_q),    64'd0);
        step();

        // Table: single fetch, simultaneous requests, ignored mresp, request stability, flushed fetch
        for (int i = 0; i < NV; i++) begin
            bus.ireq_valid   = vecs[i].iv;
            bus.ireq_addr    = vecs[i].iaddr;
            bus.ifetch_flush = vecs[i].fl;
            bus.dreq_valid   = vecs[i].dv;
            bus.dreq_addr    = vecs[i].daddr;
            bus.dreq_write   = vecs[i].dw;
            bus.dreq_size    = 3'd3;
            bus.dreq_strobe  = vecs[i].dstrb;
            bus.dreq_wdata   = vecs[i].dwdata;
            bus.mresp_valid  = vecs[i].mv;
            bus.mresp_data   = vecs[i].mdata;
            @(negedge clk);
            check($sformatf("v%0d mreq_valid", i), 64'(bus.mreq_valid), 64'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                check($sformatf("v%0d mreq_addr", i),   bus.mreq_addr,          vecs[i].e_maddr);
                check($sformatf("v%0d mreq_write", i),  64'(bus.mreq_write),    64'(vecs[i].e_mw));
                check($sformatf("v%0d mreq_strobe", i), 64'(bus.mreq_strobe),   64'(vecs[i].e_mstrb));
                check($sformatf("v%0d mreq_wdata", i),  bus.mreq_wdata,         vecs[i].e_mwdata);
            end
            check($sformatf("v%0d iresp_valid", i), 64'(bus.iresp_valid), 64'(vecs[i].e_iv));
            check($sformatf("v%0d iresp_data", i),  bus.iresp_data,       vecs[i].e_idata);
            check($sformatf("v%0d dresp_valid", i), 64'(bus.dresp_valid), 64'(vecs[i].e_dv));
            check($sformatf("v%0d dresp_data", i),  bus.dresp_data,       vecs[i].e_ddata);
            step();
        end
        clear_inputs();

        // Starvation bound: both requesters held; grants must go D,D,D,I,D,D,D,I
        bus.ireq_valid  = 1'b1;
        bus.ireq_addr   = 64'h3000;
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h3100;
        bus.dreq_write  = 1'b1;
        bus.dreq_strobe = 8'hFF;
        bus.dreq_wdata  = 64'h1111;
        for (int k = 0; k < 8; k++) begin
            bit exp_i;
            exp_i = ((k % 4) == 3);
            wait_busy($sformatf("starve%0d", k));
            check($sformatf("starve%0d mreq_addr", k), bus.mreq_addr, exp_i ? 64'h3000 : 64'h3100);
            check($sformatf("starve%0d streak", k), 64'(dut.streak_q), exp_i ? 64'd0 : 64'((k % 4) + 1));
            bus.mresp_valid = 1'b1;
            bus.mresp_data  = 64'(k);
            #1;
            check($sformatf("starve%0d iresp_valid", k), 64'(bus.iresp_valid), 64'(exp_i));
            check($sformatf("starve%0d dresp_valid", k), 64'(bus.dresp_valid), 64'(!exp_i));
            step();
            bus.mresp_valid = 1'b0;
        end
        clear_inputs();
        step();

        // Squash: flush in the 2nd BUSY_I cycle, then a D request proceeds normally
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h4000;
        step();
        @(negedge clk);
        check("squash busy1 mreq_valid", 64'(bus.mreq_valid), 64'd1);
        check("squash busy1 mreq_addr",  bus.mreq_addr,        64'h4000);
        step();
        bus.ifetch_flush = 1'b1;
        @(negedge clk);
        check("squash flush iresp_valid", 64'(bus.iresp_valid), 64'd0);
        step();
        bus.ifetch_flush = 1'b0;
        bus.ireq_valid   = 1'b0;
        bus.dreq_valid   = 1'b1;
        bus.dreq_addr    = 64'h500;
        bus.dreq_write   = 1'b0;
        bus.dreq_strobe  = 8'hFF;
        bus.mresp_valid  = 1'b1;
        bus.mresp_data   = 64'h5A;
        @(negedge clk);
        check("squash done mreq_valid",  64'(bus.mreq_valid),  64'd1);
        check("squash done iresp_valid", 64'(bus.iresp_valid), 64'd0);
        check("squash done dresp_valid", 64'(bus.dresp_valid), 64'd0);
        step();
        bus.mresp_valid = 1'b0;
        @(negedge clk);
        check("squash idle mreq_valid", 64'(bus.mreq_valid), 64'd0);
        step();
        bus.ifetch_flush = 1'b1;
        bus.mresp_valid  = 1'b1;
        bus.mresp_data   = 64'h6B;
        @(negedge clk);
        check("after squash mreq_addr",   bus.mreq_addr,         64'h500);
        check("after squash mreq_write",  64'(bus.mreq_write),   64'd0);
        check("after squash dresp_valid", 64'(bus.dresp_valid),  64'd1);
        check("after squash dresp_data",  bus.dresp_data,        64'h6B);
        check("after squash iresp_valid", 64'(bus.iresp_valid),  64'd0);
        step();
        clear_inputs();
        step();

        // Reset in the middle of a D transaction
        bus.dreq_valid  = 1'b1;
        bus.dreq_addr   = 64'h600;
        bus.dreq_write  = 1'b1;
        bus.dreq_strobe = 8'h0F;
        bus.dreq_wdata  = 64'h1234;
        step();
        @(negedge clk);
        check("rst busy mreq_valid", 64'(bus.mreq_valid), 64'd1);
        check("rst busy mreq_addr",  bus.mreq_addr,        64'h600);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        bus.dreq_valid = 1'b0;
        @(negedge clk);
        check("rst after mreq_valid", 64'(bus.mreq_valid), 64'd0);
        check("rst after streak",     64'(dut.streak_q),   64'd0);
        bus.mresp_valid = 1'b1;
        bus.mresp_data  = 64'hFEED;
        #1;
        check("rst late dresp_valid", 64'(bus.dresp_valid), 64'd0);
        check("rst late dresp_data",  bus.dresp_data,        64'd0);
        step();
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
